// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch PC, single-outstanding imem requests, instruction FIFO and redirect flush
module if_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [31:0]     NOP_INST   = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            stall_i,
  output logic            inst_valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;
  state_t          state;
  logic [XLEN-1:0] fetch_pc, req_pc;
  logic [31:0]     inst_mem [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_nxt;
  logic            push, pop, issue;
  assign push        = state == S_WAIT && imem_rvalid_i && !branch_i;
  assign pop         = inst_valid_o && !stall_i && !branch_i;
  assign count_nxt   = count + (AW+1)'(push) - (AW+1)'(pop);
  // a new request needs a free slot even counting this cycle's push
  assign issue       = !rst && !branch_i && (state == S_REQ || (state == S_WAIT && imem_rvalid_i))
                       && count_nxt < (AW+1)'(FIFO_DEPTH);
  assign imem_req_o  = issue;
  assign imem_addr_o = fetch_pc;
  assign inst_valid_o = count != '0;
  assign inst_o      = inst_valid_o ? inst_mem[rd_ptr] : NOP_INST;
  assign inst_pc_o   = inst_valid_o ? pc_mem[rd_ptr] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (branch_i) begin
      fetch_pc <= branch_target_i & ~XLEN'(3);
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= (state != S_REQ && !imem_rvalid_i) ? S_DROP : S_REQ;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        req_pc   <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      state <= issue ? S_WAIT :
               state == S_DROP ? (imem_rvalid_i ? S_REQ : S_DROP) :
               (state == S_WAIT && !imem_rvalid_i) ? S_WAIT : S_REQ;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem_rdata_i;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of fetch ordering, stall, redirect, wrap and reset
module tb_if_fetch_unit;
  logic        clk = 0, rst = 1, rst2 = 1;
  logic        req, rv, br = 0, stall = 0, iv;
  logic [31:0] addr, rdata, tgt = 0, inst, ipc;
  logic        m_rv = 0, man_rv = 0, mem_en = 1;
  logic [31:0] m_rd = 0, man_rd = 0;
  int          lat = 1;
  logic        req2, rv2 = 0, iv2;
  logic [31:0] addr2, rd2 = 0, inst2, ipc2;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign rv    = mem_en ? m_rv : man_rv;
  assign rdata = mem_en ? m_rd : man_rd;
  if_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req_o(req), .imem_addr_o(addr), .imem_rvalid_i(rv),
    .imem_rdata_i(rdata), .branch_i(br), .branch_target_i(tgt), .stall_i(stall),
    .inst_valid_o(iv), .inst_o(inst), .inst_pc_o(ipc)
  );
  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .imem_req_o(req2), .imem_addr_o(addr2), .imem_rvalid_i(rv2),
    .imem_rdata_i(rd2), .branch_i(1'b0), .branch_target_i(32'h0), .stall_i(1'b0),
    .inst_valid_o(iv2), .inst_o(inst2), .inst_pc_o(ipc2)
  );
  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h1357_0000;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset;
    tick;
    rst = 1; br = 0; stall = 0;
    repeat (3) tick;
    rst = 0;
    #1;
  endtask
  initial begin
    int pend = 0;
    logic r;
    logic [31:0] a, pa;
    pa = 0;
    forever begin
      @(posedge clk);
      r = req; a = addr;
      #1;
      m_rv = 0;
      if (rst) pend = 0;
      else begin
        if (r) begin pend = lat; pa = a; end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin m_rv = 1; m_rd = f(pa); end
        end
      end
    end
  end
  initial begin
    logic r2;
    logic [31:0] a2;
    forever begin
      @(posedge clk);
      r2 = req2; a2 = addr2;
      #1;
      rv2 = r2; rd2 = f(a2);
    end
  end
  initial begin
    int n;
    repeat (2) tick;
    check("rst_req", req, 0);
    check("rst_valid", iv, 0);
    check("rst_inst", inst, 32'h13);
    check("rst_pc", ipc, 0);
    rst = 0;
    #1;
    check("t1_req0", req, 1);
    check("t1_addr0", addr, 0);
    tick;
    check("t1_addr1", addr, 4);
    check("t1_nvalid", iv, 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("t1_valid", iv, 1);
      check("t1_pc", ipc, 4 * k);
      check("t1_inst", inst, f(4 * k));
      check("t1_addr", addr, 4 * k + 8);
    end
    lat = 1;
    do_reset;
    tick;
    tick;
    stall = 1;
    #1;
    check("t2_req_full", req, 0);
    check("t2_head0", ipc, 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check("t2_req_hold", req, 0);
      check("t2_valid_hold", iv, 1);
      check("t2_pc_hold", ipc, 0);
    end
    tick;
    stall = 0;
    #1;
    check("t2_req_resume", req, 1);
    check("t2_addr_resume", addr, 8);
    check("t2_pc_pop0", ipc, 0);
    for (int k = 1; k < 4; k++) begin
      tick;
      check("t2_pc_seq", ipc, 4 * k);
    end
    lat = 3;
    do_reset;
    n = 0;
    while (!(req && addr == 8) && n < 30) begin tick; n++; end
    check("t3_req8_cyc", n, 6);
    tick;
    br = 1; tgt = 32'h100;
    #1;
    check("t3_br_req", req, 0);
    tick;
    br = 0;
    #1;
    check("t3_flush_valid", iv, 0);
    check("t3_drop_req", req, 0);
    tick;
    check("t3_drop_rv", rv, 1);
    check("t3_drop_req2", req, 0);
    tick;
    check("t3_restart_req", req, 1);
    check("t3_restart_addr", addr, 32'h100);
    check("t3_no_stale", iv, 0);
    n = 0;
    while (!iv && n < 10) begin tick; n++; end
    check("t3_first_pc", ipc, 32'h100);
    check("t3_first_inst", inst, f(32'h100));
    lat = 1;
    do_reset;
    tick;
    br = 1; tgt = 32'h203;
    #1;
    check("t4_br_req", req, 0);
    tick;
    br = 0;
    #1;
    check("t4_valid", iv, 0);
    check("t4_req", req, 1);
    check("t4_addr", addr, 32'h200);
    tick;
    tick;
    check("t4_pc", ipc, 32'h200);
    check("t4_inst", inst, f(32'h200));
    tick;
    rst2 = 0;
    #1;
    check("t5_req", req2, 1);
    check("t5_addr0", addr2, 32'hFFFF_FFF8);
    tick;
    check("t5_addr1", addr2, 32'hFFFF_FFFC);
    tick;
    check("t5_addr2", addr2, 32'h0);
    check("t5_pc0", ipc2, 32'hFFFF_FFF8);
    tick;
    check("t5_pc1", ipc2, 32'hFFFF_FFFC);
    tick;
    check("t5_pc2", ipc2, 32'h0);
    mem_en = 0;
    do_reset;
    check("t6_addr0", addr, 0);
    tick;
    man_rv = 1; man_rd = 32'h1111;
    #1;
    check("t6_req4", addr, 4);
    tick;
    rst = 1; man_rv = 0;
    #1;
    check("t6_rst_req", req, 0);
    check("t6_rst_valid", iv, 0);
    check("t6_rst_inst", inst, 32'h13);
    check("t6_rst_pc", ipc, 0);
    tick;
    rst = 0; man_rv = 1; man_rd = 32'hBAD;
    #1;
    check("t6_restart_req", req, 1);
    check("t6_restart_addr", addr, 0);
    tick;
    man_rv = 0;
    #1;
    check("t6_late_ignored", iv, 0);
    check("t6_wait_req", req, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues word requests to instruction memory, tolerating a variable response latency with at most one request in flight.
- Buffers returned instructions with their PC in a small FIFO and presents them to the IF/ID register.
- On a branch/jump redirect it flushes the FIFO, discards any stale in-flight response, and restarts fetch at the target.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)
NOP_INST, 32'h0000_0013, value driven on inst_o when buffer empty (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
imem_req_o  out  1  fetch request; memory accepts every request in the cycle it is asserted
imem_addr_o  out  XLEN  word address of request, bits[1:0]=0
imem_rvalid_i  in  1  response valid; in order, exactly one per request, >=1 cycle after request
imem_rdata_i  in  32  instruction word
branch_i  in  1  redirect from EXE (same signal that flushes IF/ID)
branch_target_i  in  XLEN  redirect address
stall_i  in  1  downstream not accepting (load-use hazard)
inst_valid_o  out  1  buffer head valid
inst_o  out  32  head instruction, NOP_INST when empty
inst_pc_o  out  XLEN  head PC, 0 when empty

Behaviour:
- Reset (async assert, sync-safe deassert): fetch_pc=RESET_PC, state=S_REQ, FIFO empty, imem_req_o=0, inst_valid_o=0, inst_o=NOP_INST, inst_pc_o=0. Reset mid-transaction drops everything; an rvalid seen while nothing is outstanding is ignored.
- States:
  - S_REQ: nothing outstanding.
  - S_WAIT: one request outstanding; its PC is held in req_pc.
  - S_DROP: one outstanding request whose response must be discarded.
- Issue rule (combinational imem_req_o): asserted when branch_i=0 AND (state==S_REQ OR (state==S_WAIT AND imem_rvalid_i)) AND FIFO occupancy after this cycle's push/pop < FIFO_DEPTH.
- On issue: imem_addr_o=fetch_pc; req_pc<=fetch_pc; fetch_pc<=fetch_pc+4, mod 2^XLEN, so 32'hFFFF_FFFC wraps to 0. Next state is S_WAIT.
- S_WAIT with imem_rvalid_i and branch_i=0: push {imem_rdata_i, req_pc}. Next state is S_WAIT if a new request was issued this cycle, else S_REQ.
- Back-to-back throughput: 1 instruction/cycle with 1-cycle memory latency when not stalled.
- Pop: when inst_valid_o && !stall_i && !branch_i. Push and pop may occur in the same cycle, and occupancy is then unchanged. Head outputs are registered FIFO contents with no combinational path from imem_rdata_i, so minimum fetch latency is request cycle +1 (response) +1 (visible on inst_o).
- Redirect (branch_i=1), all in one cycle, with priority over push, pop and issue:
  - FIFO cleared, so inst_valid_o=0 the next cycle.
  - fetch_pc<=branch_target_i with bits[1:0] forced to 0.
  - No request is issued that cycle.
  - Any response arriving that cycle is discarded.
  - If S_WAIT and no rvalid this cycle, go to S_DROP; otherwise go to S_REQ.
- S_DROP: the next imem_rvalid_i is discarded and the state goes to S_REQ. No request is issued in S_DROP. A further branch_i in S_DROP updates fetch_pc and stays in S_DROP.
- Stall: the head is held stable; requests continue only while buffer space remains. A full buffer with stall_i=1 keeps imem_req_o=0.
- Memory sees at most one outstanding request at any time.

Test Plan:
- Reset then release, 1-cycle memory, stall_i=0 -> requests to 0x0,0x4,0x8,... on consecutive cycles; inst_pc_o=0x0 appears 2 cycles after the first request, then one instruction per cycle in order.
- Hold stall_i=1 from first inst_valid_o -> buffer fills to FIFO_DEPTH=2, imem_req_o stays 0, head holds PC 0x0. Release stall -> pops resume with PC 0x4 following.
- 3-cycle memory latency, branch_i=1 target 0x100 one cycle after request to 0x8 -> state S_DROP, the 0x8 response is discarded, the next request is 0x100, and first inst_pc_o after the flush is 0x100.
- branch_i=1 in the same cycle as imem_rvalid_i, target 0x203 -> response dropped, inst_valid_o=0 next cycle, the next request address is 0x200.
- RESET_PC=32'hFFFF_FFF8, free-running -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert rst while in S_WAIT, then late rvalid after release -> no push; fetch restarts at RESET_PC and all outputs hold reset values during rst.
